// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer: IFETCH/DECODE/EXEC/MEM/WB with a Mem_ready handshake.
// Optional macro MEM_TIMEOUT_EN adds a memory wait watchdog and a sticky ERROR state.
module multicycle_ctrl
`ifdef MEM_TIMEOUT_EN
  #(parameter int MEM_TIMEOUT = 16)
`endif
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic        Halt,
  input  logic [1:0]  Instr_class,
  input  logic        Branch_taken,
  input  logic        Mem_ready,
  output logic        PC_WE,
  output logic        IR_WE,
  output logic        A_WE,
  output logic        B_WE,
  output logic        ALU_WE,
  output logic        MDR_WE,
  output logic        RF_WE,
  output logic        PC_sel,
  output logic        Mem_rd,
  output logic        Mem_wr,
  output logic        Busy,
  output logic        Err,
  output logic [31:0] Instr_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IFETCH = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
`ifdef MEM_TIMEOUT_EN
    , ST_ERROR = 3'd6
`endif
  } state_t;

  localparam logic [1:0] CLS_ALU    = 2'd0;
  localparam logic [1:0] CLS_LOAD   = 2'd1;
  localparam logic [1:0] CLS_STORE  = 2'd2;
  localparam logic [1:0] CLS_BRANCH = 2'd3;

  state_t      state_r;
  state_t      state_next_s;
  state_t      stall_next_s;
  logic [1:0]  class_r;
  logic [31:0] instr_count_r;
  logic        retire_s;

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              timeout_s;

  assign timeout_s = (wait_cnt_r == WAIT_W'(MEM_TIMEOUT - 1)) && !Mem_ready;

  // Stalled memory state either keeps waiting or trips into ERROR
  always_comb begin
    if (timeout_s) stall_next_s = ST_ERROR;
    else           stall_next_s = state_r;
  end

  // Wait counter restarts whenever the state changes, counts while stalled
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt_r <= '0;
    end else if ((state_next_s == state_r) &&
                 ((state_r == ST_IFETCH) || (state_r == ST_MEM))) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  assign Err = (state_r == ST_ERROR);
`else
  assign stall_next_s = state_r;
  assign Err          = 1'b0;
`endif

  assign Busy        = (state_r != ST_IDLE);
  assign Instr_count = instr_count_r;

  // State, decoded class and retired-instruction counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r       <= ST_IDLE;
      class_r       <= 2'd0;
      instr_count_r <= 32'd0;
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_DECODE) class_r <= Instr_class;
      else                      class_r <= class_r;
      if (retire_s) instr_count_r <= instr_count_r + 32'd1;
      else          instr_count_r <= instr_count_r;
    end
  end

  // Next-state and output decode; an end cycle retires and picks IDLE or IFETCH on Halt
  always_comb begin
    state_next_s = state_r;
    retire_s     = 1'b0;
    PC_WE        = 1'b0;
    IR_WE        = 1'b0;
    A_WE         = 1'b0;
    B_WE         = 1'b0;
    ALU_WE       = 1'b0;
    MDR_WE       = 1'b0;
    RF_WE        = 1'b0;
    PC_sel       = 1'b0;
    Mem_rd       = 1'b0;
    Mem_wr       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Start) state_next_s = ST_IFETCH;
        else       state_next_s = ST_IDLE;
      end
      ST_IFETCH: begin
        Mem_rd = 1'b1;
        if (Mem_ready) begin
          IR_WE        = 1'b1;
          PC_WE        = 1'b1;
          state_next_s = ST_DECODE;
        end else begin
          state_next_s = stall_next_s;
        end
      end
      ST_DECODE: begin
        A_WE         = 1'b1;
        B_WE         = 1'b1;
        state_next_s = ST_EXEC;
      end
      ST_EXEC: begin
        ALU_WE = 1'b1;
        case (class_r)
          CLS_ALU:   state_next_s = ST_WB;
          CLS_LOAD,
          CLS_STORE: state_next_s = ST_MEM;
          CLS_BRANCH: begin
            PC_WE        = Branch_taken;
            PC_sel       = Branch_taken;
            retire_s     = 1'b1;
            state_next_s = Halt ? ST_IDLE : ST_IFETCH;
          end
          default:   state_next_s = ST_IDLE;
        endcase
      end
      ST_MEM: begin
        case (class_r)
          CLS_LOAD: begin
            Mem_rd = 1'b1;
            if (Mem_ready) begin
              MDR_WE       = 1'b1;
              state_next_s = ST_WB;
            end else begin
              state_next_s = stall_next_s;
            end
          end
          CLS_STORE: begin
            Mem_wr = 1'b1;
            if (Mem_ready) begin
              retire_s     = 1'b1;
              state_next_s = Halt ? ST_IDLE : ST_IFETCH;
            end else begin
              state_next_s = stall_next_s;
            end
          end
          default: state_next_s = ST_IDLE;
        endcase
      end
      ST_WB: begin
        RF_WE        = 1'b1;
        retire_s     = 1'b1;
        state_next_s = Halt ? ST_IDLE : ST_IFETCH;
      end
`ifdef MEM_TIMEOUT_EN
      ST_ERROR: state_next_s = ST_ERROR;
`endif
      default: state_next_s = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed per-cycle vector bench for multicycle_ctrl: a table of {inputs, expected outputs}
// plus hand-written sequences for counter wrap and the memory wait watchdog.
module tb_multicycle_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0, Halt = 1'b0, Branch_taken = 1'b0, Mem_ready = 1'b0;
  logic [1:0]  Instr_class = 2'd0;
  logic        PC_WE, IR_WE, A_WE, B_WE, ALU_WE, MDR_WE, RF_WE;
  logic        PC_sel, Mem_rd, Mem_wr, Busy, Err;
  logic [31:0] Instr_count;

  multicycle_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt(Halt),
    .Instr_class(Instr_class), .Branch_taken(Branch_taken), .Mem_ready(Mem_ready),
    .PC_WE(PC_WE), .IR_WE(IR_WE), .A_WE(A_WE), .B_WE(B_WE), .ALU_WE(ALU_WE),
    .MDR_WE(MDR_WE), .RF_WE(RF_WE), .PC_sel(PC_sel), .Mem_rd(Mem_rd),
    .Mem_wr(Mem_wr), .Busy(Busy), .Err(Err), .Instr_count(Instr_count)
  );

  always #5 Clk = ~Clk;

  // Output bundle: {PC_WE,IR_WE,A_WE,B_WE, ALU_WE,MDR_WE,RF_WE,PC_sel, Mem_rd,Mem_wr,Busy,Err}
  localparam logic [11:0] O_IDLE = 12'b0000_0000_0000;
  localparam logic [11:0] O_IF   = 12'b1100_0000_1010;
  localparam logic [11:0] O_RDW  = 12'b0000_0000_1010;
  localparam logic [11:0] O_DEC  = 12'b0011_0000_0010;
  localparam logic [11:0] O_EX   = 12'b0000_1000_0010;
  localparam logic [11:0] O_LDR  = 12'b0000_0100_1010;
  localparam logic [11:0] O_WB   = 12'b0000_0010_0010;
  localparam logic [11:0] O_STW  = 12'b0000_0000_0110;
  localparam logic [11:0] O_BRT  = 12'b1000_1001_0010;
`ifdef MEM_TIMEOUT_EN
  localparam logic [11:0] O_ERR  = 12'b0000_0000_0011;
`endif

  // Input bundle: {Reset_n, Start, Halt, Instr_class[1:0], Branch_taken, Mem_ready}
  typedef struct {
    logic [6:0]  in;
    logic [11:0] exp;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[34];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic [6:0] in, input logic [11:0] exp, input logic [31:0] cnt);
    vec_t v;
    v.in = in; v.exp = exp; v.cnt = cnt;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    logic [11:0] act;
    @(negedge Clk);
    {Reset_n, Start, Halt, Instr_class, Branch_taken, Mem_ready} = v.in;
    #1;
    act = {PC_WE, IR_WE, A_WE, B_WE, ALU_WE, MDR_WE, RF_WE, PC_sel, Mem_rd, Mem_wr, Busy, Err};
    n_vec++;
    if (act !== v.exp || Instr_count !== v.cnt) begin
      n_bad++;
      $display("FAIL %s: outs=%b count=%h, expected outs=%b count=%h",
               name, act, Instr_count, v.exp, v.cnt);
    end
  endtask

  initial begin
    tbl[0]  = mk(7'b0_0_0_00_0_0, O_IDLE, 32'd0);  // reset state
    tbl[1]  = mk(7'b1_1_0_00_0_0, O_IDLE, 32'd0);  // ALU, zero wait, halt at end
    tbl[2]  = mk(7'b1_1_0_00_0_1, O_IF,   32'd0);
    tbl[3]  = mk(7'b1_0_0_00_0_1, O_DEC,  32'd0);
    tbl[4]  = mk(7'b1_0_1_00_0_1, O_EX,   32'd0);
    tbl[5]  = mk(7'b1_0_1_00_0_0, O_WB,   32'd0);
    tbl[6]  = mk(7'b1_0_0_00_0_0, O_IDLE, 32'd1);
    tbl[7]  = mk(7'b1_1_0_00_0_0, O_IDLE, 32'd1);  // LOAD, 3 wait cycles in MEM
    tbl[8]  = mk(7'b1_0_0_00_0_1, O_IF,   32'd1);
    tbl[9]  = mk(7'b1_0_0_01_0_0, O_DEC,  32'd1);
    tbl[10] = mk(7'b1_0_0_00_0_0, O_EX,   32'd1);
    tbl[11] = mk(7'b1_0_0_00_0_0, O_RDW,  32'd1);
    tbl[12] = mk(7'b1_0_0_00_0_0, O_RDW,  32'd1);
    tbl[13] = mk(7'b1_0_0_00_0_0, O_RDW,  32'd1);
    tbl[14] = mk(7'b1_0_0_00_0_1, O_LDR,  32'd1);
    tbl[15] = mk(7'b1_0_0_00_0_0, O_WB,   32'd1);
    tbl[16] = mk(7'b1_0_0_00_0_0, O_RDW,  32'd2);  // STORE, fetch stall + MEM stall
    tbl[17] = mk(7'b1_0_0_00_0_1, O_IF,   32'd2);
    tbl[18] = mk(7'b1_0_0_10_0_0, O_DEC,  32'd2);
    tbl[19] = mk(7'b1_0_0_00_0_1, O_EX,   32'd2);
    tbl[20] = mk(7'b1_0_0_00_0_0, O_STW,  32'd2);
    tbl[21] = mk(7'b1_0_0_00_0_1, O_STW,  32'd2);
    tbl[22] = mk(7'b1_0_0_00_0_1, O_IF,   32'd3);  // BRANCH taken
    tbl[23] = mk(7'b1_0_0_11_0_0, O_DEC,  32'd3);
    tbl[24] = mk(7'b1_0_0_00_1_0, O_BRT,  32'd3);
    tbl[25] = mk(7'b1_0_1_00_0_1, O_IF,   32'd4);  // BRANCH not taken, Halt off-end ignored
    tbl[26] = mk(7'b1_0_1_11_1_0, O_DEC,  32'd4);
    tbl[27] = mk(7'b1_0_0_00_0_0, O_EX,   32'd4);
    tbl[28] = mk(7'b1_0_0_00_0_1, O_IF,   32'd5);  // LOAD interrupted by reset in MEM
    tbl[29] = mk(7'b1_0_0_01_0_0, O_DEC,  32'd5);
    tbl[30] = mk(7'b1_0_0_00_0_0, O_EX,   32'd5);
    tbl[31] = mk(7'b1_0_0_00_0_0, O_RDW,  32'd5);
    tbl[32] = mk(7'b0_1_0_00_0_1, O_IDLE, 32'd0);
    tbl[33] = mk(7'b1_0_0_00_0_1, O_IDLE, 32'd0);

    for (int i = 0; i < 34; i++) apply(tbl[i], $sformatf("table[%0d]", i));

    // Counter wrap: preset to all-ones while idle, retire one ALU instruction
    @(negedge Clk);
    force dut.instr_count_r = 32'hFFFF_FFFF;
    @(negedge Clk);
    release dut.instr_count_r;
    apply(mk(7'b1_1_0_00_0_0, O_IDLE, 32'hFFFF_FFFF), "wrap_start");
    apply(mk(7'b1_0_0_00_0_1, O_IF,   32'hFFFF_FFFF), "wrap_fetch");
    apply(mk(7'b1_0_0_00_0_0, O_DEC,  32'hFFFF_FFFF), "wrap_decode");
    apply(mk(7'b1_0_0_00_0_0, O_EX,   32'hFFFF_FFFF), "wrap_exec");
    apply(mk(7'b1_0_1_00_0_0, O_WB,   32'hFFFF_FFFF), "wrap_wb");
    apply(mk(7'b1_0_0_00_0_0, O_IDLE, 32'd0),         "wrap_done");

    // Fetch stall: watchdog trips after 16 waits if enabled, otherwise waits forever
    apply(mk(7'b1_1_0_00_0_0, O_IDLE, 32'd0), "stall_start");
    for (int k = 1; k <= 16; k++) apply(mk(7'b1_0_0_00_0_0, O_RDW, 32'd0), $sformatf("stall_wait[%0d]", k));
`ifdef MEM_TIMEOUT_EN
    apply(mk(7'b1_0_0_00_0_0, O_ERR, 32'd0), "timeout_err");
    apply(mk(7'b1_1_1_00_1_1, O_ERR, 32'd0), "timeout_sticky");
    apply(mk(7'b1_0_0_00_0_1, O_ERR, 32'd0), "timeout_sticky2");
    apply(mk(7'b0_0_0_00_0_0, O_IDLE, 32'd0), "timeout_reset");
    apply(mk(7'b1_0_0_00_0_0, O_IDLE, 32'd0), "timeout_released");
`else
    for (int k = 17; k <= 24; k++) apply(mk(7'b1_0_0_00_0_0, O_RDW, 32'd0), $sformatf("stall_wait[%0d]", k));
    apply(mk(7'b1_0_0_00_0_1, O_IF, 32'd0), "stall_release");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
